// File: rtl/scancode_rec.sv
// PS/2 scan-code sequence recogniser: folds E0/F0 prefixes into a single
// key event {key_code, make, brk, extended} held in a one-deep output
// register with valid/ready handshake, sticky overflow and a sequence timeout.
module scancode_rec #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_new,
    output logic [7:0] key_code,
    output logic       make,
    output logic       brk,
    output logic       extended,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow
);

    localparam int unsigned DW = 8;
    localparam int unsigned TW = 16;

    localparam logic [DW-1:0] CODE_EXT = 8'hE0;
    localparam logic [DW-1:0] CODE_BRK = 8'hF0;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic [DW-1:0]  key_code_q, key_code_d;
    logic           make_q, make_d;
    logic           brk_q, brk_d;
    logic           ext_q, ext_d;
    logic           valid_q, valid_d;
    logic           ovf_q, ovf_d;

    logic           is_ext_c;
    logic           is_brk_c;
    logic           complete_c;
    logic           ev_brk_c;
    logic           ev_ext_c;
    logic           timeout_c;
    logic           accept_c;

    assign is_ext_c   = din_new && (din == CODE_EXT);
    assign is_brk_c   = din_new && (din == CODE_BRK);
    // Any byte other than the two prefixes terminates a sequence.
    assign complete_c = din_new && !is_ext_c && !is_brk_c;
    // A pending din_new always wins over an expiring timer.
    assign timeout_c  = (state_q != S_IDLE) && (timer_q == TO_LAST) && !din_new;
    assign accept_c   = valid_q && key_ready;

    // Sequence state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode of prefix bytes and timeout.
    always_comb begin
        state_d = state_q;
        if (is_ext_c) begin
            state_d = S_EXT;
        end else if (is_brk_c) begin
            case (state_q)
                S_IDLE:    state_d = S_BRK;
                S_EXT:     state_d = S_EXT_BRK;
                S_BRK:     state_d = S_BRK;
                S_EXT_BRK: state_d = S_EXT_BRK;
                default:   state_d = S_IDLE;
            endcase
        end else if (complete_c || timeout_c) begin
            state_d = S_IDLE;
        end
    end

    // Event attributes implied by the prefixes seen so far.
    always_comb begin
        ev_brk_c = 1'b0;
        ev_ext_c = 1'b0;
        case (state_q)
            S_EXT:     ev_ext_c = 1'b1;
            S_BRK:     ev_brk_c = 1'b1;
            S_EXT_BRK: begin
                ev_brk_c = 1'b1;
                ev_ext_c = 1'b1;
            end
            default:   ;
        endcase
    end

    // Idle-cycle counter, only running inside a multi-byte sequence.
    always_comb begin
        timer_d = timer_q + TW'(1);
        if (din_new || (state_q == S_IDLE)) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // Output register: load on free slot or same-cycle accept, else drop and flag.
    always_comb begin
        key_code_d = key_code_q;
        make_d     = make_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        if (complete_c && (!valid_q || accept_c)) begin
            key_code_d = din;
            make_d     = !ev_brk_c;
            brk_d      = ev_brk_c;
            ext_d      = ev_ext_c;
            valid_d    = 1'b1;
        end else if (complete_c) begin
            ovf_d      = 1'b1;
        end else if (accept_c) begin
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code_q <= '0;
            make_q     <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            key_code_q <= key_code_d;
            make_q     <= make_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign key_code  = key_code_q;
    assign make      = make_q;
    assign brk       = brk_q;
    assign extended  = ext_q;
    assign key_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_scancode_rec.sv
// Directed bench for scancode_rec (TIMEOUT = 8). Inputs change and outputs
// are sampled on the falling clock edge.
module tb_scancode_rec;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       din_new;
    logic [7:0] key_code;
    logic       make;
    logic       brk;
    logic       extended;
    logic       key_valid;
    logic       key_ready;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    scancode_rec #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_new   (din_new),
        .key_code  (key_code),
        .make      (make),
        .brk       (brk),
        .extended  (extended),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one byte for one cycle; called and returns at a falling edge.
    task automatic send_byte(input logic [7:0] b);
        din     = b;
        din_new = 1'b1;
        @(negedge clk);
        din_new = 1'b0;
        din     = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({key_code, make, brk, extended, key_valid, overflow} !== 13'h0) begin
            errors++;
            $display("FAIL reset_async: got %h required 0000",
                     {key_code, make, brk, extended, key_valid, overflow});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Accepts the held event and checks that key_valid drops.
    task automatic consume(input string name);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_consume: key_valid=%b required 0", name, key_valid);
        end
    endtask

    task automatic check_event(input string name, input logic [7:0] code,
                               input logic mk, input logic br, input logic ex);
        checks++;
        if ({key_valid, key_code, make, brk, extended} !== {1'b1, code, mk, br, ex}) begin
            errors++;
            $display("FAIL %s: got v=%b code=%h m=%b b=%b e=%b required v=1 code=%h m=%b b=%b e=%b",
                     name, key_valid, key_code, make, brk, extended, code, mk, br, ex);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; din = 8'h00; din_new = 1'b0; key_ready = 1'b0;
        idle(2);
        checks++;
        if ({key_code, make, brk, extended, key_valid, overflow} !== 13'h0) begin
            errors++;
            $display("FAIL reset_state: got %h required 0000",
                     {key_code, make, brk, extended, key_valid, overflow});
        end
        reset = 1'b0;
        idle(1);
        key_ready = 1'b1;
        idle(2);
        key_ready = 1'b0;
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_while_empty: key_valid=%b required 0", key_valid);
        end
    endtask

    task automatic test_make();
        send_byte(8'h1C);
        check_event("make_1c", 8'h1C, 1'b1, 1'b0, 1'b0);
        idle(3);
        check_event("make_1c_held", 8'h1C, 1'b1, 1'b0, 1'b0);
        consume("make_1c");
        send_byte(8'hE1);
        check_event("plain_e1", 8'hE1, 1'b1, 1'b0, 1'b0);
        consume("plain_e1");
    endtask

    task automatic test_break();
        send_byte(8'hF0);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL f0_alone: key_valid=%b required 0", key_valid);
        end
        send_byte(8'h1C);
        check_event("break_1c", 8'h1C, 1'b0, 1'b1, 1'b0);
        consume("break_1c");
        send_byte(8'hF0);
        send_byte(8'hF0);
        send_byte(8'hAA);
        check_event("break_f0f0_aa", 8'hAA, 1'b0, 1'b1, 1'b0);
        consume("break_f0f0_aa");
    endtask

    task automatic test_extended();
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check_event("ext_break_75", 8'h75, 1'b0, 1'b1, 1'b1);
        consume("ext_break_75");
        send_byte(8'hE0);
        send_byte(8'h75);
        check_event("ext_make_75", 8'h75, 1'b1, 1'b0, 1'b1);
        consume("ext_make_75");
        send_byte(8'hF0);
        send_byte(8'hE0);
        send_byte(8'h6B);
        check_event("brk_restart_e0", 8'h6B, 1'b1, 1'b0, 1'b1);
        consume("brk_restart_e0");
        send_byte(8'hE0);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'hF0);
        send_byte(8'h4A);
        check_event("ext_brk_repeat", 8'h4A, 1'b0, 1'b1, 1'b1);
        consume("ext_brk_repeat");
    endtask

    task automatic test_overflow();
        send_byte(8'h1C);
        send_byte(8'h2A);
        check_event("ovf_held", 8'h1C, 1'b1, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: overflow=%b required 1", overflow);
        end
        consume("ovf");
        idle(3);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: overflow=%b required 1", overflow);
        end
        pulse_reset();
        send_byte(8'h1C);
        key_ready = 1'b1;
        send_byte(8'h2A);
        key_ready = 1'b0;
        check_event("back_to_back", 8'h2A, 1'b1, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_ovf: overflow=%b required 0", overflow);
        end
        consume("back_to_back");
    endtask

    task automatic test_timeout();
        send_byte(8'hE0);
        idle(7);
        send_byte(8'h1C);
        check_event("timeout_edge_ext", 8'h1C, 1'b1, 1'b0, 1'b1);
        consume("timeout_edge_ext");
        send_byte(8'hE0);
        idle(8);
        send_byte(8'h1C);
        check_event("timeout_expired", 8'h1C, 1'b1, 1'b0, 1'b0);
        consume("timeout_expired");
        send_byte(8'hF0);
        idle(12);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_no_event: key_valid=%b required 0", key_valid);
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hE0);
        send_byte(8'hF0);
        pulse_reset();
        send_byte(8'h1C);
        check_event("reset_mid_seq", 8'h1C, 1'b1, 1'b0, 1'b0);
        consume("reset_mid_seq");
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
